// File: rtl/radix2_div_pkg.sv
// Shared definitions for the radix-2 restoring divider: reset level, FSM
// state encodings and the divider opcode field of aluinfo.
package radix2_div_pkg;

  localparam logic RST_ACTIVE = 1'b0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_e;

  typedef enum logic [1:0] {
    OP_DIV  = 2'd0,
    OP_DIVU = 2'd1,
    OP_REM  = 2'd2,
    OP_REMU = 2'd3
  } div_op_e;

endpackage

// File: rtl/radix2_div_if.sv
// Start/finish handshake and operand/result bus of the divider; the master
// drives the operands, the divider (slave) returns the results.
interface radix2_div_if #(
  parameter int WIDTH = 32
) ();

  logic             i_en;
  logic             i_signed;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] R;
  logic             o_busy;
  logic             o_finish;

  modport master (
    output i_en, i_signed, A, B,
    input  Q, R, o_busy, o_finish
  );

  modport slave (
    input  i_en, i_signed, A, B,
    output Q, R, o_busy, o_finish
  );

endinterface

// File: rtl/radix2_div_step.sv
// One restoring division iteration: shift {rem,quo} left by one, try to
// subtract the divisor and keep the difference if it did not go negative.
module radix2_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // rem_i < div_i always holds, so the WIDTH+1-bit trial never overflows
  // and its msb is a valid sign.
  assign shifted = {rem_i, quo_i[WIDTH-1]};
  assign trial   = shifted - {1'b0, div_i};

  always_comb begin
    if (!trial[WIDTH]) begin
      rem_o = trial[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o = shifted[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/radix2_div.sv
// Iterative radix-2 restoring divider, signed or unsigned, one quotient bit
// per clock; quotient and remainder come out of the same run.
module radix2_div
  import radix2_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  radix2_div_if.slave bus
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;

  logic [WIDTH-1:0] step_rem, step_quo;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             a_neg, b_neg, ovf;

  // Negating 100..0 wraps to itself, which is still the right unsigned magnitude.
  assign a_neg = bus.i_signed & bus.A[WIDTH-1];
  assign b_neg = bus.i_signed & bus.B[WIDTH-1];
  assign mag_a = a_neg ? -bus.A : bus.A;
  assign mag_b = b_neg ? -bus.B : bus.B;
  assign ovf   = bus.i_signed & (bus.A == MIN_NEG) & (&bus.B);

  radix2_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .div_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    q_d       = q_q;
    r_d       = r_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.i_en) begin
          if (bus.B == '0) begin
            q_d     = '1;
            r_d     = bus.A;
            state_d = S_DONE;
          end else if (ovf) begin
            q_d     = bus.A;
            r_d     = '0;
            state_d = S_DONE;
          end else begin
            rem_d     = '0;
            quo_d     = mag_a;
            dvs_d     = mag_b;
            neg_quo_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            cnt_d     = '0;
            state_d   = S_CALC;
          end
        end
      end
      S_CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = S_FIX;
      end
      S_FIX: begin
        q_d     = neg_quo_q ? -quo_q : quo_q;
        r_d     = neg_rem_q ? -rem_q : rem_q;
        state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (i_rstn == RST_ACTIVE) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      q_q       <= '0;
      r_q       <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      q_q       <= q_d;
      r_q       <= r_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  assign bus.Q        = q_q;
  assign bus.R        = r_q;
  assign bus.o_busy   = (state_q == S_CALC) || (state_q == S_FIX);
  assign bus.o_finish = (state_q == S_DONE);

endmodule
